demultiplexer_router: RTL and testbench

//  1-to-4 registered demultiplexer: the distribution counterpart of the 4:1 multiplexer.

---
 rtl/demultiplexer_router.sv | 100 ++++++++++
 tb/tb_demultiplexer_router.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/demultiplexer_router.sv
// 1-to-4 registered demultiplexer: one valid/ready input stream steered by {s1,s0} to four
// one-entry output slots. Optional per-channel drain counters are enabled by DEMUX_COUNT_EN.
module demultiplexer_router #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               s1,
   input  logic               s0,
   input  logic [WIDTH-1:0]   in_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   c,
   output logic [WIDTH-1:0]   d,
   output logic [4*CNT_W-1:0] cnt
);

   localparam int unsigned N_CH = 4;

   logic [1:0]       sel;
   logic             accept;
   logic [N_CH-1:0]  load;
   logic [N_CH-1:0]  drain;
   logic [N_CH-1:0]  valid_d, valid_q;
   logic [WIDTH-1:0] data_d [N_CH];
   logic [WIDTH-1:0] data_q [N_CH];

   // A slot takes a new word when empty or when it drains in the same cycle (no bubble).
   always_comb begin
      sel      = {s1, s0};
      in_ready = ~valid_q[sel] | out_ready[sel];
      accept   = in_valid & in_ready;
      load     = '0;
      drain    = '0;
      valid_d  = valid_q;
      for (int i = 0; i < N_CH; i++) begin
         data_d[i]  = data_q[i];
         load[i]    = accept & (sel == 2'(i));
         drain[i]   = valid_q[i] & out_ready[i];
         valid_d[i] = load[i] | (valid_q[i] & ~drain[i]);
         if (load[i]) begin
            data_d[i] = in_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < N_CH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < N_CH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign out_valid = valid_q;
   assign a         = data_q[0];
   assign b         = data_q[1];
   assign c         = data_q[2];
   assign d         = data_q[3];

`ifdef DEMUX_COUNT_EN
   logic [CNT_W-1:0] cnt_d [N_CH];
   logic [CNT_W-1:0] cnt_q [N_CH];

   // Free-running drain counters; wrap silently.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         cnt_d[i] = drain[i] ? cnt_q[i] + CNT_W'(1) : cnt_q[i];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
   assign cnt = '0;
`endif

endmodule

// File: tb/tb_demultiplexer_router.sv
// Directed self-checking bench for demultiplexer_router.
module tb_demultiplexer_router;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CNT_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               s1, s0;
   logic [WIDTH-1:0]   in_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [WIDTH-1:0]   a, b, c, d;
   logic [4*CNT_W-1:0] cnt;

   int n_checks = 0;
   int n_fail   = 0;

   demultiplexer_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .s1(s1), .s0(s0), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .a(a), .b(b), .c(c), .d(d), .cnt(cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] chan(input int k);
      case (k)
         0: return a;
         1: return b;
         2: return c;
         default: return d;
      endcase
   endfunction

   task automatic drive(input logic v, input int k, input logic [WIDTH-1:0] w);
      in_valid = v;
      {s1, s0} = 2'(k);
      in_data  = w;
   endtask

   task automatic test_reset_initial();
      #1;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL init_out_valid: got %b expected 0000", out_valid); end
      n_checks++;
      if ({a, b, c, d} !== '0) begin n_fail++; $display("FAIL init_data: got %h %h %h %h expected all 0", a, b, c, d); end
      n_checks++;
      if (cnt !== '0) begin n_fail++; $display("FAIL init_cnt: got %h expected 0", cnt); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL init_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_routing();
      logic [WIDTH-1:0] vec [4];
      vec[0] = 32'h1; vec[1] = 32'h10; vec[2] = 32'h100; vec[3] = 32'h1000;
      out_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i, vec[i]);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL route_in_ready[%0d]: got %b expected 1", i, in_ready); end
         tick();
         n_checks++;
         if (out_valid !== 4'(1 << i)) begin n_fail++; $display("FAIL route_valid[%0d]: got %b expected %b", i, out_valid, 4'(1 << i)); end
         n_checks++;
         if (chan(i) !== vec[i]) begin n_fail++; $display("FAIL route_data[%0d]: got %h expected %h", i, chan(i), vec[i]); end
      end
      drive(1'b0, 0, '0);
      tick();
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL route_drained: got %b expected 0000", out_valid); end
      n_checks++;
      if (a !== 32'h1 || d !== 32'h1000) begin n_fail++; $display("FAIL route_hold_after_drain: got a=%h d=%h expected 1 1000", a, d); end
   endtask

   task automatic test_back_pressure();
      out_ready = 4'b1011;
      drive(1'b1, 2, 32'hAAAA);
      tick();
      drive(1'b1, 2, 32'hBBBB);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
      tick();
      n_checks++;
      if (c !== 32'hAAAA || out_valid[2] !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got c=%h v=%b expected AAAA 1", c, out_valid[2]); end
      out_ready = 4'hF;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_high: got %b expected 1", in_ready); end
      tick();
      n_checks++;
      if (c !== 32'hBBBB || out_valid !== 4'b0100) begin n_fail++; $display("FAIL bp_replace: got c=%h v=%b expected BBBB 0100", c, out_valid); end
      drive(1'b0, 0, '0);
      tick();
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_drained: got %b expected 0000", out_valid); end
   endtask

   task automatic test_independence();
      out_ready = 4'b1011;
      drive(1'b1, 2, 32'hCCCC);
      tick();
      drive(1'b1, 0, 32'h5);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ind_in_ready: got %b expected 1", in_ready); end
      tick();
      n_checks++;
      if (a !== 32'h5 || out_valid !== 4'b0101) begin n_fail++; $display("FAIL ind_a: got a=%h v=%b expected 5 0101", a, out_valid); end
      n_checks++;
      if (c !== 32'hCCCC) begin n_fail++; $display("FAIL ind_c_stable: got %h expected CCCC", c); end
      drive(1'b0, 0, '0);
      tick();
      n_checks++;
      if (out_valid !== 4'b0100 || c !== 32'hCCCC) begin n_fail++; $display("FAIL ind_c_stall: got v=%b c=%h expected 0100 CCCC", out_valid, c); end
      out_ready = 4'hF;
      tick();
   endtask

   task automatic test_streaming();
      logic [WIDTH-1:0] w;
      out_ready = 4'hF;
      for (int j = 0; j < 8; j++) begin
         w = 32'hD000 + 32'(j);
         drive(1'b1, 3, w);
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", j, in_ready); end
         tick();
         n_checks++;
         if (d !== w || out_valid !== 4'b1000) begin n_fail++; $display("FAIL stream_d[%0d]: got d=%h v=%b expected %h 1000", j, d, out_valid, w); end
      end
      drive(1'b0, 0, '0);
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 4'b1110;
      drive(1'b1, 0, 32'h77);
      tick();
      drive(1'b0, 0, '0);
      n_checks++;
      if (out_valid !== 4'b0001 || a !== 32'h77) begin n_fail++; $display("FAIL rst_pre_hold: got v=%b a=%h expected 0001 77", out_valid, a); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0000", out_valid); end
      n_checks++;
      if ({a, b, c, d} !== '0) begin n_fail++; $display("FAIL rst_data: got %h %h %h %h expected all 0", a, b, c, d); end
      n_checks++;
      if (cnt !== '0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cnt_ready: got cnt=%h rdy=%b expected 0 1", cnt, in_ready); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_counter();
      logic [4*CNT_W-1:0] exp_cnt;
`ifdef DEMUX_COUNT_EN
      exp_cnt = {8'd0, 8'd0, 8'd1, 8'd0};
`else
      exp_cnt = '0;
`endif
      out_ready = 4'hF;
      for (int j = 0; j < 257; j++) begin
         drive(1'b1, 1, 32'(j));
         tick();
      end
      drive(1'b0, 0, '0);
      tick();
      n_checks++;
      if (out_valid !== 4'b0000 || b !== 32'd256) begin n_fail++; $display("FAIL cnt_b_last: got v=%b b=%h expected 0000 100", out_valid, b); end
      n_checks++;
      if (cnt !== exp_cnt) begin n_fail++; $display("FAIL cnt_wrap: got %h expected %h", cnt, exp_cnt); end
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 4'h0;
      drive(1'b0, 0, '0);
      test_reset_initial();
      @(posedge clk); #1;
      rst = 1'b0;
      test_routing();
      test_back_pressure();
      test_independence();
      test_streaming();
      test_reset_mid();
      test_counter();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
